signal_engine: RTL and testbench

//  Downstream consumer of the feature stream (ret/ema, Q16.16, valid/ready). Combines each

---
 rtl/fxp_pkg.sv | 30 +++
 rtl/signal_engine.sv | 128 ++++++++++++
 tb/tb_signal_engine.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fxp_pkg.sv
// Shared Q16.16 types and helpers for the feature/signal path: position and
// order-side encodings, default entry thresholds and the saturating add.
package fxp_pkg;

   typedef enum logic [1:0] {
      POS_FLAT  = 2'b00,
      POS_LONG  = 2'b01,
      POS_SHORT = 2'b10
   } pos_state_t;

   typedef enum logic [1:0] {
      SIDE_NONE = 2'b00,
      SIDE_BUY  = 2'b01,
      SIDE_SELL = 2'b10
   } order_side_t;

   localparam logic signed [31:0] DEF_BUY_TH  = 32'sh0000_8000;
   localparam logic signed [31:0] DEF_SELL_TH = 32'shFFFF_8000;

   // 33-bit sum; a carry that disagrees with the sign bit means overflow.
   function automatic logic signed [31:0] sat_add32(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
      logic [32:0] s;
      s = {a[31], a} + {b[31], b};
      if (s[32] != s[31])
         return s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
      return s[31:0];
   endfunction

endpackage

// File: rtl/signal_engine.sv
// Scores each feature sample, tracks a FLAT/LONG/SHORT position with cooldown
// on re-entry, and emits one order per position change on a 1-deep output stage.
//
//   state     | meaning
//   POS_FLAT  | no position; entries allowed once cooldown reaches zero
//   POS_LONG  | long; leaves to FLAT on a negative score
//   POS_SHORT | short; leaves to FLAT on a positive score
module signal_engine
   import fxp_pkg::*;
#(
   parameter logic signed [31:0] BUY_TH    = DEF_BUY_TH,
   parameter logic signed [31:0] SELL_TH   = DEF_SELL_TH,
   parameter int                 RET_SHIFT = 2,
   parameter int                 COOLDOWN  = 2,
   parameter int                 SEQ_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      ret_in,
   input  logic [31:0]      ema_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       order_side,
   output logic [31:0]      order_score,
   output logic [SEQ_W-1:0] order_seq,
   output logic [1:0]       pos_state
);

   localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

   logic signed [31:0] ret_scaled;
   logic signed [31:0] score;
   logic               accept;
   logic               consume;

   pos_state_t         pos_q, pos_d;
   logic [CW-1:0]      cool_q, cool_d;
   logic               emit;
   order_side_t        side_d;

   order_side_t        side_q;
   logic [SEQ_W-1:0]   seq_cnt;

   assign ret_scaled = $signed(ret_in) >>> RET_SHIFT;
   assign score      = sat_add32($signed(ema_in), ret_scaled);

   assign in_ready = ~out_valid | out_ready;
   assign accept   = in_valid & in_ready;
   assign consume  = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pos_q  <= POS_FLAT;
         cool_q <= '0;
      end else begin
         pos_q  <= pos_d;
         cool_q <= cool_d;
      end
   end

   always_comb begin
      pos_d  = pos_q;
      cool_d = cool_q;
      emit   = 1'b0;
      side_d = SIDE_NONE;
      if (accept) begin
         case (pos_q)
            POS_FLAT: begin
               if (cool_q == '0) begin
                  if (score > BUY_TH) begin
                     pos_d  = POS_LONG;
                     emit   = 1'b1;
                     side_d = SIDE_BUY;
                  end else if (score < SELL_TH) begin
                     pos_d  = POS_SHORT;
                     emit   = 1'b1;
                     side_d = SIDE_SELL;
                  end
               end
            end
            POS_LONG: begin
               if (score < 32'sd0) begin
                  pos_d  = POS_FLAT;
                  emit   = 1'b1;
                  side_d = SIDE_SELL;
               end
            end
            POS_SHORT: begin
               if (score > 32'sd0) begin
                  pos_d  = POS_FLAT;
                  emit   = 1'b1;
                  side_d = SIDE_BUY;
               end
            end
            default: pos_d = POS_FLAT;
         endcase
         // Exits also reload the cooldown, so re-entry waits after any change.
         if (emit)
            cool_d = CW'(COOLDOWN);
         else if (cool_q != '0)
            cool_d = cool_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         side_q      <= SIDE_NONE;
         order_score <= '0;
         order_seq   <= '0;
         seq_cnt     <= '0;
      end else if (emit) begin
         out_valid   <= 1'b1;
         side_q      <= side_d;
         order_score <= score;
         order_seq   <= seq_cnt;
         seq_cnt     <= seq_cnt + SEQ_W'(1);
      end else if (consume) begin
         out_valid   <= 1'b0;
      end
   end

   assign order_side = side_q;
   assign pos_state  = pos_q;

endmodule

// File: tb/tb_signal_engine.sv
// Scoreboard bench for signal_engine: directed and random samples against a
// plain-arithmetic position model, plus a COOLDOWN=0 instance for sequence wrap.
module tb_signal_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- instance A: default parameters ----------------
   logic        a_rst_n = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
   logic [31:0] a_ret = '0, a_ema = '0;
   logic        a_in_ready, a_out_valid;
   logic [1:0]  a_side, a_pos;
   logic [31:0] a_score;
   logic [15:0] a_seq;

   signal_engine dut_a (
      .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .ret_in(a_ret), .ema_in(a_ema), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .order_side(a_side), .order_score(a_score), .order_seq(a_seq), .pos_state(a_pos)
   );

   // ---------------- instance B: no cooldown, sequence wrap ----------------
   logic        b_rst_n = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
   logic [31:0] b_ret = '0, b_ema = '0;
   logic        b_in_ready, b_out_valid;
   logic [1:0]  b_side, b_pos;
   logic [31:0] b_score;
   logic [15:0] b_seq;

   signal_engine #(.COOLDOWN(0)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .ret_in(b_ret), .ema_in(b_ema), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .order_side(b_side), .order_score(b_score), .order_seq(b_seq), .pos_state(b_pos)
   );

   // ---------------- reference model ----------------
   typedef struct {
      int side;
      int score;
      int seq;
   } ord_t;

   ord_t qa[$];
   bit   a_new = 0;
   int   ma_pos = 0, ma_cool = 0, ma_seq = 0;

   // pos: 0 flat, 1 long, 2 short.  side: 1 buy, 2 sell.
   task automatic ref_step(input int cd, input int ret, input int ema,
                           inout int pos, inout int cool,
                           output bit emit, output int side, output int sc);
      longint s;
      longint maxv, minv;
      maxv = 64'sd2147483647;
      minv = -64'sd2147483648;
      s = longint'(ema) + longint'(ret >>> 2);
      if (s > maxv) s = maxv;
      if (s < minv) s = minv;
      sc   = int'(s);
      emit = 0;
      side = 0;
      if (pos == 0) begin
         if (cool == 0 && sc > 32768)       begin pos = 1; emit = 1; side = 1; end
         else if (cool == 0 && sc < -32768) begin pos = 2; emit = 1; side = 2; end
      end else if (pos == 1) begin
         if (sc < 0) begin pos = 0; emit = 1; side = 2; end
      end else begin
         if (sc > 0) begin pos = 0; emit = 1; side = 1; end
      end
      if (emit) cool = cd;
      else if (cool > 0) cool = cool - 1;
   endtask

   task automatic drive_a(input bit v, input logic [31:0] r, input logic [31:0] e, input bit rdy);
      bit   emit;
      int   side, sc;
      ord_t o;
      @(negedge clk);
      a_in_valid  = v;
      a_ret       = r;
      a_ema       = e;
      a_out_ready = rdy;
      #1;
      chk("pos_state", a_pos, ma_pos);
      if (a_in_valid && a_in_ready) begin
         ref_step(2, int'(r), int'(e), ma_pos, ma_cool, emit, side, sc);
         if (emit) begin
            o.side  = side;
            o.score = sc;
            o.seq   = ma_seq;
            ma_seq  = (ma_seq + 1) & 32'hFFFF;
            qa.push_back(o);
            a_new = 1;
         end
      end
   endtask

   task automatic reset_a();
      @(negedge clk);
      a_rst_n     = 1'b0;
      a_in_valid  = 1'b0;
      a_out_ready = 1'b0;
      qa.delete();
      a_new   = 0;
      ma_pos  = 0;
      ma_cool = 0;
      ma_seq  = 0;
      @(negedge clk);
      #1;
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_pos", a_pos, 0);
      chk("rst_seq", a_seq, 0);
      chk("rst_side", a_side, 0);
      chk("rst_score", a_score, 0);
      chk("rst_in_ready", a_in_ready, 1);
      a_rst_n = 1'b1;
   endtask

   // Monitor A: orders pushed this cycle are not visible until after the edge.
   always @(negedge clk) begin
      ord_t o;
      int   vis;
      #2;
      if (a_rst_n) begin
         vis = qa.size() - (a_new ? 1 : 0);
         chk("out_valid", a_out_valid, vis > 0);
         if (a_out_valid && a_out_ready && vis > 0) begin
            o = qa.pop_front();
            chk("order_side", a_side, o.side);
            chk("order_score", a_score, o.score);
            chk("order_seq", a_seq, o.seq);
         end
      end
      a_new = 0;
   end

   // Monitor B: alternating BUY/SELL with a free-running expected sequence.
   int b_cnt = 0;
   localparam int B_N = 65540;

   always @(negedge clk) begin
      #2;
      if (b_rst_n && b_out_valid && b_out_ready) begin
         chk("b_seq", b_seq, b_cnt & 32'hFFFF);
         chk("b_side", b_side, (b_cnt % 2 == 0) ? 1 : 2);
         b_cnt++;
      end
   end

   logic [1:0]  cap_side;
   logic [31:0] cap_score;
   logic [15:0] cap_seq;

   initial begin
      fork
         begin : stream_a
            // reset while an order is pending in LONG
            reset_a();
            for (int k = 0; k < 2; k++) begin
               drive_a(1, 32'h0, 32'h0001_0000, 1);
               drive_a(1, 32'h0, 32'hFFFF_0000, 1);
               drive_a(1, 32'h0, 32'h0, 1);
               drive_a(1, 32'h0, 32'h0, 1);
            end
            drive_a(1, 32'h0, 32'h0001_0000, 0);
            drive_a(0, 32'h0, 32'h0, 0);
            chk("pend_valid", a_out_valid, 1);
            chk("pend_pos", a_pos, 1);
            chk("pend_seq", a_seq, 4);
            reset_a();

            // entry, hold, exit, then cooldown-blocked re-entry
            drive_a(1, 32'h0, 32'h0001_0000, 1);
            drive_a(1, 32'h0, 32'h0000_4000, 1);
            drive_a(1, 32'h0, 32'hFFFF_0000, 1);
            repeat (3) drive_a(1, 32'h0, 32'hFFFF_0000, 1);
            // score exactly zero holds SHORT, positive exits
            drive_a(1, 32'h0, 32'h0, 1);
            drive_a(1, 32'h0, 32'h0000_8000, 1);
            drive_a(1, 32'h0, 32'h0, 1);
            drive_a(1, 32'h0, 32'h0, 1);
            // threshold equality and shifted negative ret do not enter
            drive_a(1, 32'hFFFF_FFFF, 32'h0000_8001, 1);
            drive_a(1, 32'h0, 32'h0000_8000, 1);
            drive_a(1, 32'h0, 32'hFFFF_8000, 1);
            drive_a(1, 32'h0, 32'h0000_8001, 1);

            // back-pressure: order held, input blocked
            drive_a(1, 32'h0, 32'hFFFF_0000, 0);
            chk("stall_in_ready", a_in_ready, 0);
            cap_side  = a_side;
            cap_score = a_score;
            cap_seq   = a_seq;
            repeat (4) begin
               drive_a(1, 32'h0, 32'hFFFF_0000, 0);
               chk("stall_in_ready", a_in_ready, 0);
               chk("stall_side", a_side, cap_side);
               chk("stall_score", a_score, cap_score);
               chk("stall_seq", a_seq, cap_seq);
            end
            drive_a(1, 32'h0, 32'hFFFF_0000, 1);
            chk("release_in_ready", a_in_ready, 1);
            drive_a(0, 32'h0, 32'h0, 1);

            // saturation both ways
            reset_a();
            drive_a(1, 32'h7FFF_0000, 32'h7FFF_0000, 1);
            drive_a(1, 32'h8000_0000, 32'h8000_0000, 1);

            // random mix
            reset_a();
            for (int i = 0; i < 1500; i++) begin
               int cls;
               logic [31:0] r, e;
               cls = int'($urandom_range(0, 9));
               if (cls == 0) begin
                  e = $urandom;
                  r = $urandom;
               end else if (cls == 1) begin
                  r = 32'h0;
                  case ($urandom_range(0, 2))
                     0:       e = 32'h0000_8000;
                     1:       e = 32'hFFFF_8000;
                     default: e = 32'h0;
                  endcase
               end else begin
                  e = int'($urandom_range(0, 32'h40000)) - 32'sh20000;
                  r = int'($urandom_range(0, 32'h80000)) - 32'sh40000;
               end
               drive_a($urandom_range(0, 3) != 0, r, e, $urandom_range(0, 3) != 0);
            end
            repeat (4) drive_a(0, 32'h0, 32'h0, 1);
            chk("a_drained", qa.size(), 0);
         end
         begin : stream_b
            repeat (2) @(negedge clk);
            b_rst_n = 1'b1;
            for (int i = 0; i < B_N; i++) begin
               @(negedge clk);
               b_in_valid = 1'b1;
               b_ema      = (i % 2 == 0) ? 32'h0001_0000 : 32'hFFFF_0000;
            end
            @(negedge clk);
            b_in_valid = 1'b0;
            repeat (3) @(negedge clk);
            #3;
            chk("b_orders", b_cnt, B_N);
         end
      join
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
